// File: rtl/dma_engine_if.sv
// Memory-side bus of the block DMA engine: one request channel and one response channel.
// The engine drives the request side (master); the memory drives the response side (slave).
interface dma_engine_if #(
  parameter int WORD_BITS = 32
);
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_we;
  logic [31:0]          mem_req_addr;
  logic [WORD_BITS-1:0] mem_req_wdata;
  logic                 mem_rsp_valid;
  logic [WORD_BITS-1:0] mem_rsp_rdata;
  logic                 mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/dma_engine.sv
// Block DMA engine: moves one BLOCK_BITS block to/from memory one word at a time,
// keeping a single request outstanding, with bus-error and response-timeout abort.
module dma_engine #(
  parameter int BLOCK_BITS = 1024,
  parameter int WORD_BITS  = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_start,
  input  logic                  tx_start,
  input  logic [31:0]           rx_address,
  input  logic [31:0]           tx_address,
  input  logic [BLOCK_BITS-1:0] tx_data,
  output logic [BLOCK_BITS-1:0] rx_data,
  output logic                  done,
  output logic                  idle,
  output logic                  error,
  dma_engine_if.master          mem
);
  localparam int NWORDS = BLOCK_BITS / WORD_BITS;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;

  state_t                state_q, state_d;
  logic [31:0]           base_q, base_d;
  logic [BLOCK_BITS-1:0] buf_q, buf_d;
  logic [BLOCK_BITS-1:0] rx_q, rx_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  last;

  assign last = (widx_q == WIDX_W'(NWORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      buf_q   <= '0;
      rx_q    <= '0;
      widx_q  <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
      rx_q    <= rx_d;
      widx_q  <= widx_d;
      to_q    <= to_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    buf_d   = buf_q;
    rx_d    = rx_q;
    widx_d  = widx_q;
    to_d    = to_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rx wins a simultaneous start; a misaligned base skips the bus entirely
        if (rx_start) begin
          base_d  = rx_address;
          widx_d  = '0;
          to_d    = '0;
          err_d   = (rx_address[1:0] != 2'b00);
          state_d = (rx_address[1:0] != 2'b00) ? FIN : RD_REQ;
        end else if (tx_start) begin
          base_d  = tx_address;
          buf_d   = tx_data;
          widx_d  = '0;
          to_d    = '0;
          err_d   = (tx_address[1:0] != 2'b00);
          state_d = (tx_address[1:0] != 2'b00) ? FIN : WR_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        if (mem.mem_req_ready) begin
          to_d    = '0;
          state_d = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem.mem_rsp_valid) begin
          if (mem.mem_rsp_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            if (state_q == RD_WAIT) rx_d[WORD_BITS*widx_q +: WORD_BITS] = mem.mem_rsp_rdata;
            if (last) begin
              state_d = FIN;
            end else begin
              widx_d  = widx_q + 1'b1;
              state_d = (state_q == RD_WAIT) ? RD_REQ : WR_REQ;
            end
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields come straight from registers, so they cannot move during a stall
  assign mem.mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem.mem_req_we    = (state_q == WR_REQ);
  assign mem.mem_req_addr  = base_q + 32'({widx_q, 2'b00});
  assign mem.mem_req_wdata = buf_q[WORD_BITS*widx_q +: WORD_BITS];

  assign rx_data = rx_q;
  assign done    = done_q;
  assign idle    = (state_q == IDLE);
  assign error   = err_q;
endmodule

// File: tb/tb_dma_engine.sv
// Randomized bench for dma_engine: a behavioural memory responder plus a block-level
// model of expected bus traffic and rx_data.
module tb_dma_engine;
  localparam int BB = 1024, WB = 32, NW = 32, TO = 1024;

  logic          clk = 1'b0, rst = 1'b0;
  logic          rx_start = 1'b0, tx_start = 1'b0;
  logic [31:0]   rx_address = '0, tx_address = '0;
  logic [BB-1:0] tx_data = '0;
  logic [BB-1:0] rx_data;
  logic          done, idle, error;

  dma_engine_if #(.WORD_BITS(WB)) mem ();

  dma_engine #(.BLOCK_BITS(BB), .WORD_BITS(WB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_start(rx_start), .tx_start(tx_start),
    .rx_address(rx_address), .tx_address(tx_address), .tx_data(tx_data),
    .rx_data(rx_data), .done(done), .idle(idle), .error(error), .mem(mem)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // memory behaviour knobs and request log
  bit          ident = 1'b0, rnd_ready = 1'b0, no_rsp = 1'b0, stray = 1'b0, pend = 1'b0;
  logic [31:0] mem_base = '0, mem_xor = '0, pend_addr = '0;
  int          stall_left = 0, err_word = -1, max_dly = 0, dly = 0, pend_idx = 0;
  logic [31:0] q_addr[$];
  bit          q_we[$];
  logic [31:0] q_wdata[$];
  logic [31:0] exp_rx[NW];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ident) return (a - mem_base) >> 2;
    return (a * 32'h9E3779B1) ^ mem_xor;
  endfunction

  function automatic logic [BB-1:0] pack_rx();
    logic [BB-1:0] r;
    for (int k = 0; k < NW; k++) r[WB*k +: WB] = exp_rx[k];
    return r;
  endfunction

  function automatic logic [31:0] rnd_aligned();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  task automatic clear_log();
    q_addr.delete(); q_we.delete(); q_wdata.delete();
  endtask

  always @(negedge clk) begin
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_err   = 1'b0;
    if (stray) begin
      mem.mem_rsp_valid = 1'b1;
      mem.mem_rsp_rdata = 32'hDEAD_BEEF;
      stray = 1'b0;
    end
    if (pend) begin
      if (dly == 0) begin
        pend = 1'b0;
        if (!no_rsp) begin
          mem.mem_rsp_valid = 1'b1;
          mem.mem_rsp_rdata = mem_word(pend_addr);
          mem.mem_rsp_err   = (pend_idx == err_word);
        end
      end else dly--;
    end
    if (stall_left > 0) begin
      mem.mem_req_ready = 1'b0;
      if (mem.mem_req_valid) stall_left--;
    end else begin
      mem.mem_req_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (mem.mem_req_valid && mem.mem_req_ready) begin
      q_addr.push_back(mem.mem_req_addr);
      q_we.push_back(mem.mem_req_we);
      q_wdata.push_back(mem.mem_req_wdata);
      pend      = 1'b1;
      pend_addr = mem.mem_req_addr;
      pend_idx  = q_addr.size() - 1;
      dly       = (max_dly > 0) ? $urandom_range(0, max_dly) : 0;
    end
  end

  // Pulse a start, then count edges (the accepting edge is 1) until done or bound.
  task automatic run_xfer(input bit rs, input bit ts, input logic [31:0] ra, input logic [31:0] ta,
                          input logic [BB-1:0] td, input bit chg, input int pulse_at, input int bound,
                          output int cyc, output bit got, output logic e1);
    @(negedge clk);
    rx_start = rs; tx_start = ts; rx_address = ra; tx_address = ta; tx_data = td;
    cyc = 0; got = 1'b0; e1 = 1'bx;
    while (!got && cyc < bound) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 1) begin
        rx_start = 1'b0; tx_start = 1'b0; e1 = error;
        if (chg) tx_data = ~td;
      end
      if (cyc == pulse_at) begin
        rx_start = 1'b1; tx_start = 1'b1; rx_address = ra ^ 32'h100; tx_address = ta ^ 32'h200;
      end
      if (cyc == pulse_at + 1) begin rx_start = 1'b0; tx_start = 1'b0; end
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_chk++; if (mem.mem_req_valid !== 1'b0 || mem.mem_req_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: valid %b we %b want 0 0", mem.mem_req_valid, mem.mem_req_we); end
    n_chk++; if (mem.mem_req_addr !== 32'h0 || mem.mem_req_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_fields: addr %h wdata %h want 0 0", mem.mem_req_addr, mem.mem_req_wdata); end
    n_chk++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data: got nonzero want 0"); end
    for (int k = 0; k < NW; k++) exp_rx[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_rx_ident();
    int cyc; bit got; logic e1;
    ident = 1'b1; mem_base = 32'h1000; clear_log();
    run_xfer(1'b1, 1'b0, 32'h1000, 32'h0, '0, 1'b0, 0, 200, cyc, got, e1);
    n_chk++; if (!got || cyc != 66) begin n_fail++; $display("FAIL rx_latency: done %b at %0d want 66", got, cyc); end
    n_chk++; if (error !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL rx_flags: error %b idle %b want 0 1", error, idle); end
    n_chk++; if (q_addr.size() != NW) begin n_fail++; $display("FAIL rx_nreq: got %0d want %0d", q_addr.size(), NW); end
    for (int k = 0; k < NW && k < q_addr.size(); k++) begin
      n_chk++; if (q_addr[k] !== 32'h1000 + 32'(4*k) || q_we[k] !== 1'b0) begin
        n_fail++; $display("FAIL rx_addr[%0d]: got %h we %b want %h we 0", k, q_addr[k], q_we[k], 32'h1000 + 32'(4*k)); end
    end
    for (int k = 0; k < NW; k++) begin
      exp_rx[k] = 32'(k);
      n_chk++; if (rx_data[WB*k +: WB] !== exp_rx[k]) begin
        n_fail++; $display("FAIL rx_word[%0d]: got %h want %h", k, rx_data[WB*k +: WB], exp_rx[k]); end
    end
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rx_done_pulse: got %b want 0", done); end
    ident = 1'b0;
  endtask

  task automatic test_tx_wrap();
    int cyc; bit got; logic e1; logic [BB-1:0] td; logic [31:0] a;
    for (int k = 0; k < NW; k++) td[WB*k +: WB] = $urandom();
    clear_log();
    run_xfer(1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0, td, 1'b1, 0, 200, cyc, got, e1);
    n_chk++; if (!got || cyc != 66) begin n_fail++; $display("FAIL tx_latency: done %b at %0d want 66", got, cyc); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL tx_error: got %b want 0", error); end
    n_chk++; if (q_addr.size() != NW) begin n_fail++; $display("FAIL tx_nreq: got %0d want %0d", q_addr.size(), NW); end
    for (int k = 0; k < NW && k < q_addr.size(); k++) begin
      a = 32'hFFFF_FFF0 + 32'(4*k);
      n_chk++; if (q_addr[k] !== a || q_we[k] !== 1'b1 || q_wdata[k] !== td[WB*k +: WB]) begin
        n_fail++; $display("FAIL tx_word[%0d]: addr %h we %b data %h want %h 1 %h", k, q_addr[k], q_we[k], q_wdata[k], a, td[WB*k +: WB]); end
    end
    n_chk++; if (rx_data !== pack_rx()) begin n_fail++; $display("FAIL tx_rx_data_kept: rx_data changed by tx"); end
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL tx_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_misaligned();
    int cyc; bit got; logic e1;
    clear_log();
    run_xfer(1'b1, 1'b0, 32'h1002, 32'h0, '0, 1'b0, 0, 20, cyc, got, e1);
    n_chk++; if (!got || cyc != 2) begin n_fail++; $display("FAIL mis_done: done %b at %0d want 2", got, cyc); end
    n_chk++; if (error !== 1'b1) begin n_fail++; $display("FAIL mis_error: got %b want 1", error); end
    n_chk++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL mis_nreq: got %0d want 0", q_addr.size()); end
    run_xfer(1'b0, 1'b1, 32'h0, rnd_aligned(), '1, 1'b0, 0, 200, cyc, got, e1);
    n_chk++; if (e1 !== 1'b0) begin n_fail++; $display("FAIL mis_error_clear: got %b want 0", e1); end
    n_chk++; if (!got || error !== 1'b0) begin n_fail++; $display("FAIL mis_next_xfer: done %b error %b want 1 0", got, error); end
  endtask

  task automatic test_rsp_err();
    int cyc; bit got; logic e1; logic [31:0] base;
    base = rnd_aligned(); mem_xor = $urandom(); err_word = 5; clear_log();
    run_xfer(1'b1, 1'b0, base, 32'h0, '0, 1'b0, 0, 200, cyc, got, e1);
    n_chk++; if (!got || error !== 1'b1) begin n_fail++; $display("FAIL err_abort: done %b error %b want 1 1", got, error); end
    n_chk++; if (q_addr.size() != 6) begin n_fail++; $display("FAIL err_nreq: got %0d want 6", q_addr.size()); end
    for (int k = 0; k < 5; k++) exp_rx[k] = mem_word(base + 32'(4*k));
    n_chk++; if (rx_data !== pack_rx()) begin n_fail++; $display("FAIL err_rx_data: words 0-4 new, rest old not matched"); end
    err_word = -1;
  endtask

  task automatic test_stall_timeout();
    int cyc, n; bit ok; logic [31:0] a, wd; logic we;
    stall_left = 10; no_rsp = 1'b1; clear_log();
    @(negedge clk); rx_start = 1'b1; rx_address = rnd_aligned();
    @(posedge clk); #1 rx_start = 1'b0;
    a = mem.mem_req_addr; we = mem.mem_req_we; wd = mem.mem_req_wdata;
    n_chk++; if (mem.mem_req_valid !== 1'b1 || a !== rx_address) begin
      n_fail++; $display("FAIL stall_first: valid %b addr %h want 1 %h", mem.mem_req_valid, a, rx_address); end
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      n_chk++; if (mem.mem_req_valid !== 1'b1 || mem.mem_req_addr !== a || mem.mem_req_we !== we || mem.mem_req_wdata !== wd) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid %b addr %h want 1 %h", i, mem.mem_req_valid, mem.mem_req_addr, a); end
    end
    cyc = 0;
    while (mem.mem_req_valid && cyc < 20) begin @(posedge clk); cyc++; #1; end
    n = 0; ok = 1'b0;
    while (!ok && n < TO + 20) begin @(posedge clk); n++; #1; if (done) ok = 1'b1; end
    n_chk++; if (!ok || n != TO + 1) begin n_fail++; $display("FAIL timeout_latency: done %b after %0d want %0d", ok, n, TO + 1); end
    n_chk++; if (error !== 1'b1 || q_addr.size() != 1) begin
      n_fail++; $display("FAIL timeout_abort: error %b nreq %0d want 1 1", error, q_addr.size()); end
    n_chk++; if (rx_data !== pack_rx()) begin n_fail++; $display("FAIL timeout_rx_data: rx_data changed"); end
    no_rsp = 1'b0; stall_left = 0;
  endtask

  task automatic test_priority();
    int cyc; bit got; logic e1; logic [31:0] ra, ta; int bad;
    ra = rnd_aligned(); ta = rnd_aligned(); mem_xor = $urandom(); clear_log();
    run_xfer(1'b1, 1'b1, ra, ta, '1, 1'b0, 10, 200, cyc, got, e1);
    n_chk++; if (!got || error !== 1'b0) begin n_fail++; $display("FAIL prio_done: done %b error %b want 1 0", got, error); end
    n_chk++; if (q_addr.size() != NW) begin n_fail++; $display("FAIL prio_nreq: got %0d want %0d", q_addr.size(), NW); end
    bad = 0;
    for (int k = 0; k < NW && k < q_addr.size(); k++)
      if (q_addr[k] !== ra + 32'(4*k) || q_we[k] !== 1'b0) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL prio_reads_only: %0d bad requests want 0", bad); end
    for (int k = 0; k < NW; k++) exp_rx[k] = mem_word(ra + 32'(4*k));
    n_chk++; if (rx_data !== pack_rx()) begin n_fail++; $display("FAIL prio_rx_data: block read mismatched"); end
  endtask

  task automatic test_random();
    int cyc, bad; bit got, is_rx; logic e1; logic [31:0] base; logic [BB-1:0] td;
    rnd_ready = 1'b1; max_dly = 3;
    for (int it = 0; it < 6; it++) begin
      is_rx = $urandom_range(0, 1); base = rnd_aligned(); mem_xor = $urandom();
      for (int k = 0; k < NW; k++) td[WB*k +: WB] = $urandom();
      clear_log();
      run_xfer(is_rx, !is_rx, base, base, td, 1'b1, 0, 2000, cyc, got, e1);
      n_chk++; if (!got || error !== 1'b0) begin n_fail++; $display("FAIL rand%0d_done: done %b error %b want 1 0", it, got, error); end
      bad = (q_addr.size() != NW) ? 1 : 0;
      for (int k = 0; k < NW && k < q_addr.size(); k++)
        if (q_addr[k] !== base + 32'(4*k) || q_we[k] !== !is_rx || (!is_rx && q_wdata[k] !== td[WB*k +: WB])) bad++;
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_bus: %0d bad requests want 0", it, bad); end
      if (is_rx) for (int k = 0; k < NW; k++) exp_rx[k] = mem_word(base + 32'(4*k));
      n_chk++; if (rx_data !== pack_rx()) begin n_fail++; $display("FAIL rand%0d_rx_data: block mismatched", it); end
    end
    rnd_ready = 1'b0; max_dly = 0;
  endtask

  task automatic test_reset_mid();
    int cyc, bad; logic [BB-1:0] td;
    for (int k = 0; k < NW; k++) td[WB*k +: WB] = $urandom();
    clear_log();
    @(negedge clk); tx_start = 1'b1; tx_address = rnd_aligned(); tx_data = td;
    @(posedge clk); #1 tx_start = 1'b0;
    cyc = 0;
    while (!(q_addr.size() == 12 && mem.mem_req_valid) && cyc < 100) begin @(posedge clk); cyc++; #1; end
    n_chk++; if (cyc >= 100) begin n_fail++; $display("FAIL rstmid_reach: word 12 not reached in %0d cycles", cyc); end
    rst = 1'b1; #1;
    n_chk++; if (mem.mem_req_valid !== 1'b0 || idle !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: valid %b idle %b done %b want 0 1 0", mem.mem_req_valid, idle, done); end
    for (int k = 0; k < NW; k++) exp_rx[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0; stray = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || idle !== 1'b1 || mem.mem_req_valid !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d bad cycles want 0", bad); end
    n_chk++; if (q_addr.size() != 12 || rx_data !== pack_rx()) begin
      n_fail++; $display("FAIL rstmid_state: nreq %0d want 12 or rx_data not cleared", q_addr.size()); end
  endtask

  initial begin
    mem.mem_req_ready = 1'b0; mem.mem_rsp_valid = 1'b0; mem.mem_rsp_rdata = '0; mem.mem_rsp_err = 1'b0;
    test_reset();
    test_rx_ident();
    test_tx_wrap();
    test_misaligned();
    test_rsp_err();
    test_stall_timeout();
    test_priority();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have parameter BLOCK_BITS, default 1024, meaning bits moved per transfer.
REQ-002 SHALL have parameter WORD_BITS, default 32, meaning memory bus data width; BLOCK_BITS/WORD_BITS = NWORDS (default 32).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles to wait for a memory response.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- rx_start  in  1  one-cycle request to read a block from memory
- tx_start  in  1  one-cycle request to write a block to memory
- rx_address  in  32  byte base address for rx
- tx_address  in  32  byte base address for tx
- tx_data  in  BLOCK_BITS  block to write
- rx_data  out  BLOCK_BITS  block read
- done  out  1  one-cycle completion pulse
- idle  out  1  engine accepts a start
- error  out  1  last transfer aborted
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus request accepted
- mem_req_we  out  1  1 means write, 0 means read
- mem_req_addr  out  32  word byte address
- mem_req_wdata  out  WORD_BITS  write word
- mem_rsp_valid  in  1  response for the outstanding request (reads and writes)
- mem_rsp_rdata  in  WORD_BITS  read word
- mem_rsp_err  in  1  bus error, qualified by mem_rsp_valid

Function
REQ-006 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and FIN.
REQ-007 SHALL sample rx_start and tx_start only in IDLE; a start in any other state SHALL be ignored.
REQ-008 SHALL give rx_start priority when rx_start and tx_start are high in the same cycle; tx_start is dropped.
REQ-009 SHALL latch the base address on an accepted start; for tx it SHALL also capture tx_data into an internal buffer, so later changes to tx_data have no effect.
REQ-010 SHALL deassert idle in the cycle after an accepted start and reassert it in the cycle done pulses.
REQ-011 SHALL, when base[1:0] != 0, skip all bus traffic, go directly to FIN, and set error.
REQ-012 SHALL use address base + 4*k for word k, k = 0..NWORDS-1, with wrap-around modulo 2^32.
REQ-013 SHALL keep at most one request outstanding:
- RD_REQ/WR_REQ: assert mem_req_valid.
- Go to RD_WAIT/WR_WAIT in the cycle after mem_req_valid && mem_req_ready.
- Issue the next word in the cycle after mem_rsp_valid.
REQ-014 SHALL hold mem_req_addr, mem_req_we and mem_req_wdata stable while mem_req_valid is high and mem_req_ready is low.
REQ-015 SHALL write rx_data[WORD_BITS*k +: WORD_BITS] with mem_rsp_rdata for read word k; for tx, word k SHALL come from buffer bits [WORD_BITS*k +: WORD_BITS].
REQ-016 SHALL leave rx_data unchanged by tx transfers; rx_data is valid from done until the next accepted rx_start.
REQ-017 SHALL ignore mem_rsp_valid while not in RD_WAIT/WR_WAIT.
REQ-018 SHALL count cycles in RD_WAIT/WR_WAIT; reaching TIMEOUT without a response SHALL abort.
REQ-019 SHALL abort on mem_rsp_valid && mem_rsp_err; an abort (from this or REQ-018) SHALL:
- issue no further words;
- go to FIN;
- set error.
REQ-020 SHALL treat error as sticky: high from FIN until the next accepted start, which clears it.
REQ-021 SHALL, after the last word's response (or an abort), enter FIN; FIN SHALL pulse done for exactly one cycle and return to IDLE.
REQ-022 SHALL complete a fault-free transfer with zero-wait bus (ready=1, response one cycle after accept) in 2*NWORDS+2 cycles from the start pulse to done.

Reset
REQ-023 SHALL, while rst is high and independent of clk, put the engine in IDLE with:
- idle=1
- done=0, error=0
- mem_req_valid=0, mem_req_we=0
- mem_req_addr=0, mem_req_wdata=0
- rx_data=0
- word counter and timeout counter cleared.
REQ-024 SHALL, on reset mid-transfer, abandon the transfer with no done pulse; responses arriving afterwards SHALL be ignored.

Verification
REQ-025 rx_start, rx_address=0x1000, zero-wait memory with word[i]=i -> addresses 0x1000..0x107C, rx_data word k = k, done at cycle 66, error=0.
REQ-026 tx_start, tx_address=0xFFFFFFF0, tx_data changed right after start -> writes the original data at addresses 0xFFFFFFF0..0x0000006C (wrapping), done pulses once.
REQ-027 rx_start with address 0x1002 -> no mem_req_valid, done and error in FIN; a following valid start clears error.
REQ-028 mem_rsp_err on word 5 of a read -> exactly 6 requests issued, done=1 and error=1, rx_data words 0-4 updated.
REQ-029 mem_req_ready held low 10 cycles and no response for TIMEOUT -> request fields stable while stalled, abort with error at timeout; rx_start and tx_start together -> read only.
REQ-030 rst asserted at word 12 of a tx -> mem_req_valid=0 immediately, idle=1, no done pulse.
